// File: rtl/viterbi_pkg.sv
// ==== viterbi_pkg: shared 8-state rate-1/2 Viterbi definitions | rev 1.0 ====
`default_nettype none

package viterbi_pkg;

  localparam int NUM_STATES = 8;
  localparam int BM_W       = 2;

  typedef logic [BM_W-1:0] bm_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fsm_state_t;

  // Predecessor of state j when the shifted-out bit was b.
  function automatic logic [2:0] pred(input logic [2:0] j, input logic b);
    return {j[1:0], b};
  endfunction

endpackage

`default_nettype wire

// File: rtl/acs_unit.sv
// ==== acs_unit: saturating add, compare, select for one trellis state | rev 1.0 ====
`default_nettype none

module acs_unit
  import viterbi_pkg::*;
#(
  parameter int PM_W = 8
) (
  input  logic [PM_W-1:0] pm0,
  input  logic [PM_W-1:0] pm1,
  input  logic [BM_W-1:0] bm0,
  input  logic [BM_W-1:0] bm1,
  output logic [PM_W-1:0] pm_sel,
  output logic            dec
);

  logic [PM_W:0]   w_sum0;
  logic [PM_W:0]   w_sum1;
  logic [PM_W-1:0] w_c0;
  logic [PM_W-1:0] w_c1;

  assign w_sum0 = {1'b0, pm0} + {{(PM_W-1){1'b0}}, bm0};
  assign w_sum1 = {1'b0, pm1} + {{(PM_W-1){1'b0}}, bm1};

  assign w_c0 = w_sum0[PM_W] ? {PM_W{1'b1}} : w_sum0[PM_W-1:0];
  assign w_c1 = w_sum1[PM_W] ? {PM_W{1'b1}} : w_sum1[PM_W-1:0];

  // Ties go to the even predecessor.
  assign dec    = (w_c1 < w_c0);
  assign pm_sel = dec ? w_c1 : w_c0;

endmodule

`default_nettype wire

// File: rtl/acs_path_metric_unit.sv
// ==== acs_path_metric_unit: 8-state ACS with metric registers, normalization and frame FSM | rev 1.0 ====
`default_nettype none

module acs_path_metric_unit
  import viterbi_pkg::*;
#(
  parameter int PM_W      = 8,
  parameter int PM_INIT   = 15,
  parameter int FRAME_LEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            in_valid,
  input  logic [31:0]     bm_in,
  output logic [7:0]      dec_out,
  output logic            dec_valid,
  output logic            dec_last,
  output logic [2:0]      best_state,
  output logic [PM_W-1:0] best_metric,
  output logic            busy
);

  localparam int              CNT_W     = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CNT_W-1:0] C_LAST    = CNT_W'(FRAME_LEN - 1);
  localparam logic [PM_W-1:0]  C_HALF    = {1'b1, {(PM_W-1){1'b0}}};
  localparam logic [PM_W-1:0]  C_PM_INIT = PM_W'(PM_INIT);

  fsm_state_t       r_state;
  fsm_state_t       w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_next_cnt;

  logic [PM_W-1:0]  r_pm   [NUM_STATES];
  logic [PM_W-1:0]  w_src  [NUM_STATES];
  logic [PM_W-1:0]  w_sel  [NUM_STATES];
  logic [PM_W-1:0]  w_norm [NUM_STATES];
  logic [7:0]       w_dec;
  logic             w_all_hi;
  logic [2:0]       w_best_state;
  logic [PM_W-1:0]  w_best_metric;
  logic             w_accept;
  logic             w_last;

  assign w_accept = in_valid && (start || (r_state == RUN));
  assign w_last   = in_valid && !start && (r_state == RUN) && (r_cnt == C_LAST);
  assign busy     = (r_state == RUN);

  // A start symbol runs the ACS from the init vector rather than the registers.
  always_comb begin
    for (int i = 0; i < NUM_STATES; i++) begin
      w_src[i] = start ? ((i == 0) ? '0 : C_PM_INIT) : r_pm[i];
    end
  end

  for (genvar j = 0; j < NUM_STATES; j++) begin : g_acs
    localparam int P0 = int'(pred(3'(j), 1'b0));
    localparam int P1 = int'(pred(3'(j), 1'b1));
    localparam int B  = j / 4;

    acs_unit #(
      .PM_W (PM_W)
    ) u_acs (
      .pm0    (w_src[P0]),
      .pm1    (w_src[P1]),
      .bm0    (bm_in[4*P0 + 2*B +: BM_W]),
      .bm1    (bm_in[4*P1 + 2*B +: BM_W]),
      .pm_sel (w_sel[j]),
      .dec    (w_dec[j])
    );
  end

  always_comb begin
    w_all_hi = 1'b1;
    for (int j = 0; j < NUM_STATES; j++) begin
      w_all_hi = w_all_hi & w_sel[j][PM_W-1];
    end
    for (int j = 0; j < NUM_STATES; j++) begin
      w_norm[j] = w_all_hi ? (w_sel[j] - C_HALF) : w_sel[j];
    end
    // Strict compare keeps the lowest index on ties.
    w_best_state  = '0;
    w_best_metric = w_norm[0];
    for (int j = 1; j < NUM_STATES; j++) begin
      if (w_norm[j] < w_best_metric) begin
        w_best_metric = w_norm[j];
        w_best_state  = 3'(j);
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    if (in_valid) begin
      if (start) begin
        w_next_state = RUN;
        w_next_cnt   = CNT_W'(1);
      end else if (r_state == RUN) begin
        if (r_cnt == C_LAST) begin
          w_next_state = IDLE;
          w_next_cnt   = '0;
        end else begin
          w_next_cnt   = r_cnt + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_STATES; i++) begin
        r_pm[i] <= (i == 0) ? '0 : C_PM_INIT;
      end
      dec_out     <= '0;
      dec_valid   <= 1'b0;
      dec_last    <= 1'b0;
      best_state  <= '0;
      best_metric <= '0;
    end else begin
      dec_valid <= w_accept;
      dec_last  <= w_last;
      if (w_accept) begin
        for (int i = 0; i < NUM_STATES; i++) begin
          r_pm[i] <= w_norm[i];
        end
        dec_out     <= w_dec;
        best_state  <= w_best_state;
        best_metric <= w_best_metric;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_acs_path_metric_unit.sv
// ==== tb_acs_path_metric_unit: directed self-checking bench for acs_path_metric_unit | rev 1.0 ====
`default_nettype none

module tb_acs_path_metric_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] bm_in = '0;
  logic [7:0]  dec_out;
  logic        dec_valid;
  logic        dec_last;
  logic [2:0]  best_state;
  logic [7:0]  best_metric;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] mpm [8];
  logic [7:0] exp_dec;
  logic [2:0] exp_bs;
  logic [7:0] exp_bm;

  always #5 clk = ~clk;

  acs_path_metric_unit #(
    .PM_W      (8),
    .PM_INIT   (15),
    .FRAME_LEN (64)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .in_valid    (in_valid),
    .bm_in       (bm_in),
    .dec_out     (dec_out),
    .dec_valid   (dec_valid),
    .dec_last    (dec_last),
    .best_state  (best_state),
    .best_metric (best_metric),
    .busy        (busy)
  );

  // Drive on the falling edge, return 1 time unit after the rising edge.
  task automatic drive_symbol(input logic s, input logic v, input logic [31:0] bm);
    @(negedge clk);
    start    = s;
    in_valid = v;
    bm_in    = bm;
    @(posedge clk);
    #1;
  endtask

  // Reference trellis step used for long runs.
  task automatic model_step(input logic [31:0] bm, input logic st);
    int src [8];
    int sel [8];
    int c0, c1, p0, b;
    bit hi;
    for (int i = 0; i < 8; i++) src[i] = st ? ((i == 0) ? 0 : 15) : int'(mpm[i]);
    hi = 1'b1;
    for (int j = 0; j < 8; j++) begin
      p0 = (j % 4) * 2;
      b  = j / 4;
      c0 = src[p0]     + int'(bm[4*p0 + 2*b +: 2]);
      c1 = src[p0 + 1] + int'(bm[4*(p0+1) + 2*b +: 2]);
      if (c0 > 255) c0 = 255;
      if (c1 > 255) c1 = 255;
      exp_dec[j] = (c1 < c0);
      sel[j] = (c1 < c0) ? c1 : c0;
      if (sel[j] < 128) hi = 1'b0;
    end
    exp_bs = 3'd0;
    for (int j = 0; j < 8; j++) begin
      if (hi) sel[j] = sel[j] - 128;
      mpm[j] = 8'(sel[j]);
    end
    exp_bm = mpm[0];
    for (int j = 1; j < 8; j++) begin
      if (mpm[j] < exp_bm) begin
        exp_bm = mpm[j];
        exp_bs = 3'(j);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (dec_out !== 8'h00) begin errors++; $display("FAIL reset_dec_out got %h want 00", dec_out); end
    checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL reset_dec_valid got %b want 0", dec_valid); end
    checks++; if (dec_last !== 1'b0) begin errors++; $display("FAIL reset_dec_last got %b want 0", dec_last); end
    checks++; if (best_state !== 3'd0) begin errors++; $display("FAIL reset_best_state got %0d want 0", best_state); end
    checks++; if (best_metric !== 8'd0) begin errors++; $display("FAIL reset_best_metric got %0d want 0", best_metric); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_start_and_ties();
    drive_symbol(1'b1, 1'b1, 32'h0000_0000);
    checks++; if (dec_valid !== 1'b1) begin errors++; $display("FAIL start_dec_valid got %b want 1", dec_valid); end
    checks++; if (dec_out !== 8'h00) begin errors++; $display("FAIL start_dec_out got %h want 00", dec_out); end
    checks++; if (best_state !== 3'd0) begin errors++; $display("FAIL start_best_state got %0d want 0", best_state); end
    checks++; if (best_metric !== 8'd0) begin errors++; $display("FAIL start_best_metric got %0d want 0", best_metric); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL start_busy got %b want 1", busy); end
    // pm = {0,15,15,15,0,15,15,15}; bm[1][*]=0, rest 3 -> all ties/even wins, min 3 at state 0
    drive_symbol(1'b0, 1'b1, 32'hFFFF_FF0F);
    checks++; if (dec_out !== 8'h00) begin errors++; $display("FAIL tie_dec_out got %h want 00", dec_out); end
    checks++; if (best_state !== 3'd0) begin errors++; $display("FAIL tie_best_state got %0d want 0", best_state); end
    checks++; if (best_metric !== 8'd3) begin errors++; $display("FAIL tie_best_metric got %0d want 3", best_metric); end
    drive_symbol(1'b0, 1'b0, 32'h0000_0000);
    checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL idle_dec_valid got %b want 0", dec_valid); end
    checks++; if (best_metric !== 8'd3) begin errors++; $display("FAIL idle_hold_metric got %0d want 3", best_metric); end
  endtask

  task automatic test_decisions();
    // Even predecessors cost 3, odd cost 0: every 15-vs-15 pair picks odd.
    drive_symbol(1'b1, 1'b1, 32'h0F0F_0F0F);
    checks++; if (dec_out !== 8'hEE) begin errors++; $display("FAIL odd_dec_out got %h want ee", dec_out); end
    checks++; if (best_metric !== 8'd3) begin errors++; $display("FAIL odd_best_metric got %0d want 3", best_metric); end
    // pm = {3,15,15,15,3,15,15,15}; bm[0][1]=1, rest 3 -> state 4 reaches 4
    drive_symbol(1'b0, 1'b1, 32'hFFFF_FFF7);
    checks++; if (dec_out !== 8'h00) begin errors++; $display("FAIL bit_dec_out got %h want 00", dec_out); end
    checks++; if (best_state !== 3'd4) begin errors++; $display("FAIL bit_best_state got %0d want 4", best_state); end
    checks++; if (best_metric !== 8'd4) begin errors++; $display("FAIL bit_best_metric got %0d want 4", best_metric); end
  endtask

  task automatic test_frame();
    int pulses = 0;
    drive_symbol(1'b1, 1'b1, 32'h0);
    if (dec_valid === 1'b1) pulses++;
    for (int k = 1; k < 64; k++) begin
      if (k % 5 == 0) begin
        drive_symbol(1'b0, 1'b0, 32'h0);
        checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL gap_dec_valid k=%0d got %b want 0", k, dec_valid); end
      end
      drive_symbol(1'b0, 1'b1, 32'h0);
      if (dec_valid === 1'b1) pulses++;
      checks++; if (dec_last !== (k == 63)) begin errors++; $display("FAIL frame_dec_last k=%0d got %b want %b", k, dec_last, (k == 63)); end
      checks++; if (busy !== (k != 63)) begin errors++; $display("FAIL frame_busy k=%0d got %b want %b", k, busy, (k != 63)); end
    end
    checks++; if (pulses != 64) begin errors++; $display("FAIL frame_pulses got %0d want 64", pulses); end
    drive_symbol(1'b0, 1'b1, 32'h0);
    checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL after_frame_dec_valid got %b want 0", dec_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL after_frame_busy got %b want 0", busy); end
  endtask

  task automatic test_normalization();
    for (int n = 0; n < 200; n++) begin
      drive_symbol((n % 64) == 0, 1'b1, 32'hFFFF_FFFF);
      model_step(32'hFFFF_FFFF, (n % 64) == 0);
      checks++; if (dec_out !== exp_dec) begin errors++; $display("FAIL norm_dec_out n=%0d got %h want %h", n, dec_out, exp_dec); end
      checks++; if (best_state !== exp_bs) begin errors++; $display("FAIL norm_best_state n=%0d got %0d want %0d", n, best_state, exp_bs); end
      checks++; if (best_metric !== exp_bm) begin errors++; $display("FAIL norm_best_metric n=%0d got %0d want %0d", n, best_metric, exp_bm); end
      checks++; if (best_metric >= 8'd128) begin errors++; $display("FAIL norm_range n=%0d got %0d want below 128", n, best_metric); end
    end
  endtask

  task automatic test_restart();
    drive_symbol(1'b1, 1'b1, 32'hFFFF_FFFF);
    for (int k = 1; k < 10; k++) drive_symbol(1'b0, 1'b1, 32'hFFFF_FFFF);
    // Reinitialized metrics give 0xEE; stale equal metrics would give odd picks at states 0/4 too.
    drive_symbol(1'b1, 1'b1, 32'h0F0F_0F0F);
    checks++; if (dec_out !== 8'hEE) begin errors++; $display("FAIL restart_dec_out got %h want ee", dec_out); end
    checks++; if (best_metric !== 8'd3) begin errors++; $display("FAIL restart_best_metric got %0d want 3", best_metric); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL restart_busy got %b want 1", busy); end
    checks++; if (dec_last !== 1'b0) begin errors++; $display("FAIL restart_dec_last got %b want 0", dec_last); end
    for (int k = 1; k < 64; k++) begin
      drive_symbol(1'b0, 1'b1, 32'h0);
      checks++; if (dec_last !== (k == 63)) begin errors++; $display("FAIL restart_last k=%0d got %b want %b", k, dec_last, (k == 63)); end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL restart_end_busy got %b want 0", busy); end
  endtask

  task automatic test_async_reset();
    drive_symbol(1'b1, 1'b1, 32'h0F0F_0F0F);
    drive_symbol(1'b0, 1'b1, 32'hFFFF_FFF7);
    #2;
    rst = 1'b0;
    #1;
    checks++; if (dec_out !== 8'h00) begin errors++; $display("FAIL arst_dec_out got %h want 00", dec_out); end
    checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL arst_dec_valid got %b want 0", dec_valid); end
    checks++; if (best_state !== 3'd0) begin errors++; $display("FAIL arst_best_state got %0d want 0", best_state); end
    checks++; if (best_metric !== 8'd0) begin errors++; $display("FAIL arst_best_metric got %0d want 0", best_metric); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arst_busy got %b want 0", busy); end
    @(negedge clk);
    rst = 1'b1;
    drive_symbol(1'b0, 1'b1, 32'h0);
    checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL arst_nonstart_valid got %b want 0", dec_valid); end
    drive_symbol(1'b1, 1'b1, 32'h0);
    checks++; if (dec_valid !== 1'b1) begin errors++; $display("FAIL arst_start_valid got %b want 1", dec_valid); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL arst_start_busy got %b want 1", busy); end
    checks++; if (best_metric !== 8'd0) begin errors++; $display("FAIL arst_start_metric got %0d want 0", best_metric); end
  endtask

  initial begin
    test_reset();
    test_start_and_ties();
    test_decisions();
    test_frame();
    test_normalization();
    test_restart();
    test_async_reset();
    drive_symbol(1'b0, 1'b0, 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/acs_path_metric_unit.md
# acs_path_metric_unit

Add-compare-select stage of the 8-state, rate-1/2 Viterbi decoder. It consumes the two 2-bit branch metrics produced per trellis state by the branch-metric units. It updates eight registered path metrics once per accepted symbol and emits one survivor-decision byte per symbol to the traceback memory. Frame sequencing, metric saturation and normalization are handled locally.

## Interface
- `PM_W`, 8: path-metric width in bits.
- `PM_INIT`, 15: initial metric of states 1..7 at frame start; state 0 starts at 0.
- `FRAME_LEN`, 64: symbols per frame; must be at least 2.
- `clk` input, 1: sole clock; all state changes on rising edge.
- `rst` input, 1: asynchronous, active-low reset.
- `start` input, 1: qualified by `in_valid`; the current symbol is the first of a new frame.
- `in_valid` input, 1: `bm_in` holds a valid symbol this cycle.
- `bm_in` input, 32: `bm_in[4p+2b +: 2]` is the metric for leaving state p with input bit b.
- `dec_out` output, 8: bit j = 1 when state j's survivor came from odd predecessor.
- `dec_valid` output, 1: `dec_out`/`best_*` valid this cycle.
- `dec_last` output, 1: with `dec_valid`, the last symbol of the frame.
- `best_state` output, 3: argmin of the updated metrics.
- `best_metric` output, PM_W: the minimum updated metric.
- `busy` output, 1: FSM in RUN.

## Operation
- Trellis: state j has predecessors p0={j[1:0],0} and p1={j[1:0],1}; input bit is j[2].
- Candidate c0 = pm[p0] + bm[p0][j[2]]; c1 = pm[p1] + bm[p1][j[2]].
- Sums saturate at 2^PM_W-1.
- Select the strictly smaller candidate. On a tie select c0 (decision 0).
- On a `start` symbol, the ACS uses the init vector {0, PM_INIT x7} in place of the registered metrics.
- Normalization: if all eight selected metrics are ≥ 2^(PM_W-1), subtract 2^(PM_W-1) from each before registering. `best_metric` reports the post-normalization value.
- `best_state` takes the lowest index on ties.
- FSM has two states, IDLE and RUN, plus a symbol counter `cnt` of ceil(log2(FRAME_LEN)) bits.
  - IDLE: `in_valid` without `start` is ignored (no update, no `dec_valid`). `in_valid`&`start` processes the symbol, sets cnt=1, and moves to RUN.
  - RUN: `in_valid` without `start` processes the symbol and increments cnt. The symbol with cnt==FRAME_LEN-1 sets `dec_last` and returns to IDLE.
  - RUN with `in_valid`&`start`: the frame restarts. Metrics are reinitialized, cnt=1, the state stays RUN, and no `dec_last` is produced for the abandoned frame.
- Idle cycles (`in_valid`=0) hold all metrics and the counter.

## Timing
- Latency is 1 cycle: the symbol accepted at edge n gives `dec_valid`=1 with its outputs after edge n. The next path metrics are registered at the same edge.
- `dec_valid` and `dec_last` are single-cycle pulses. The other outputs hold until the next valid symbol.
- Full throughput: one symbol per cycle, no backpressure.
- Reset (asynchronous, any time including mid-frame):
  - pm[0]=0, pm[1..7]=PM_INIT, FSM=IDLE, cnt=0.
  - `dec_out`=0, `dec_valid`=0, `dec_last`=0, `best_state`=0, `best_metric`=0, `busy`=0.
- `busy` is registered: high the cycle after the first symbol, low the cycle after the last symbol.

## Structure
- `viterbi_pkg` holds the shared decoder definitions:
  - constants NUM_STATES=8 and BM_W=2;
  - the typedef `bm_t` (logic[1:0]);
  - the function `pred(j,b)` that returns predecessor states.
- Sub-module `acs_unit` is combinational and instantiated 8×: two metrics plus two branch metrics in, saturated add, compare, select, decision bit out.
- The top level owns the metric registers, normalization, argmin tree, FSM and counter.

## Test plan
- Reset then `start` with all `bm_in`=0 → `dec_out`=0x00; new pm = {0,15,15,15,0,15,15,15}; `best_state`=0; `best_metric`=0; `busy`=1 next cycle.
- `start`, then a second symbol with bm[1][b]=0 and all others=3 → check each `dec_out` bit against the trellis model; exercises ties resolving to decision 0.
- Drive FRAME_LEN valid symbols with gaps of `in_valid`=0 → exactly FRAME_LEN `dec_valid` pulses; `dec_last` only on the 64th; `busy` falls after it; a following non-start symbol is ignored.
- All bm=3 for 200 symbols with PM_W=8 → no metric ever wraps; normalization fires whenever all metrics ≥128, and the post-normalization `best_metric` stays <128.
- Mid-frame at symbol 10, `start` → metrics reinitialized; counter restarts; `dec_last` occurs 64 symbols after the restart.
- Assert `rst` low mid-frame asynchronously → outputs go to reset values immediately, without waiting for a clock edge; no `dec_valid` until the next `start`.
